alu_op_scheduler: RTL

//   Shares one alu_final datapath between two requesters (port 0, port 1).

---
 rtl/alu_op_scheduler_pkg.sv | 26 ++
 rtl/alu_op_scheduler_alu.sv | 47 ++++
 rtl/alu_op_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_op_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_scheduler_pkg                                                       |
// | Shared op-codes, FSM state encoding and compare-vector bit positions.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_op_scheduler_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  // Compare vector is {A>B, A==B, A<B}
  localparam int CMP_GT_BIT = 2;
  localparam int CMP_EQ_BIT = 1;
  localparam int CMP_LT_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_scheduler_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_scheduler_alu                                                       |
// | Combinational alu_final datapath: add/sub with carry/borrow, compare, and. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_op_scheduler_alu
  import alu_op_scheduler_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [1:0]        s,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              flag,
  output logic [2:0]        cmp
);

  logic [DATA_W:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = '0;
    flag   = 1'b0;
    cmp    = '0;
    case (s)
      OP_ADD: begin
        result = w_sum[DATA_W-1:0];
        flag   = w_sum[DATA_W];
      end
      OP_SUB: begin
        result = a - b;
        flag   = (a < b);
      end
      OP_CMP: begin
        cmp[CMP_GT_BIT] = (a > b);
        cmp[CMP_EQ_BIT] = (a == b);
        cmp[CMP_LT_BIT] = (a < b);
      end
      default: result = a & b;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_op_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_scheduler                                                           |
// | Two-port arbiter sharing one ALU; IDLE->EXEC->RESP with registered reply.  |
// | Option: ALU_SCHED_FIXED_PRIO_EN gives port 0 strict priority.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_op_scheduler
  import alu_op_scheduler_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ID_W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_flag,
  output logic [2:0]        rsp_cmp
);

  state_t            r_state;
  state_t            w_next_state;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [ID_W-1:0]   r_id;
  logic              w_grant0;
  logic              w_grant1;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_flag;
  logic [2:0]        w_alu_cmp;

`ifdef ALU_SCHED_FIXED_PRIO_EN
  assign w_grant0 = req0_valid;
  assign w_grant1 = req1_valid & ~req0_valid;
`else
  // Pointer holds the last contention winner; the other port wins next contention
  logic r_rr_ptr;
  assign w_grant0 = req0_valid & (~req1_valid | r_rr_ptr);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_rr_ptr);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        if (w_grant0 | w_grant1) w_next_state = ST_EXEC;
      end
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= OP_ADD;
      r_a        <= '0;
      r_b        <= '0;
      r_id       <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flag   <= 1'b0;
      rsp_cmp    <= '0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      r_rr_ptr   <= 1'b1;
`endif
    end else begin
      if (r_state == ST_IDLE && (w_grant0 | w_grant1)) begin
        if (w_grant1) begin
          r_op <= req1_op;
          r_a  <= req1_a;
          r_b  <= req1_b;
        end else begin
          r_op <= req0_op;
          r_a  <= req0_a;
          r_b  <= req0_b;
        end
        r_id <= ID_W'(w_grant1);
`ifndef ALU_SCHED_FIXED_PRIO_EN
        if (req0_valid && req1_valid) r_rr_ptr <= w_grant1;
`endif
      end
      // Response fields only change here, so they stay frozen through RESP
      if (r_state == ST_EXEC) begin
        rsp_id     <= r_id;
        rsp_result <= w_alu_result;
        rsp_flag   <= w_alu_flag;
        rsp_cmp    <= w_alu_cmp;
      end
    end
  end

  alu_op_scheduler_alu #(
    .DATA_W (DATA_W)
  ) u_alu_final (
    .s      (r_op),
    .a      (r_a),
    .b      (r_b),
    .result (w_alu_result),
    .flag   (w_alu_flag),
    .cmp    (w_alu_cmp)
  );

endmodule
`default_nettype wire
